// File: rtl/vga_box_fill.sv
// rtl/vga_box_fill.sv - filled-rectangle pixel sequencer for vga_adapter (160x120, 3-bit colour)
// Optional full-screen clear command enabled by defining VGA_BOX_CLEAR_EN.
module vga_box_fill #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [COLOUR_W-1:0] colour_in,
`ifdef VGA_BOX_CLEAR_EN
    input  logic                clear,
`endif
    output logic                busy,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    state_t state, state_nx;

    logic [X_W-1:0]      bx, bw, cx, cx_nx, eff_x0, eff_w;
    logic [Y_W-1:0]      by, bh, cy, cy_nx, eff_y0, eff_h;
    logic [COLOUR_W-1:0] bcol, pix_col;
    logic                zero_size, row_end, last_px, px_vis;
    logic [X_W:0]        px_sum;
    logic [Y_W:0]        py_sum;

`ifdef VGA_BOX_CLEAR_EN
    always_comb begin
        eff_x0 = clear ? '0 : x0;
        eff_y0 = clear ? '0 : y0;
        eff_w  = clear ? X_W'(SCREEN_W) : width;
        eff_h  = clear ? Y_W'(SCREEN_H) : height;
    end
`else
    always_comb begin
        eff_x0 = x0;
        eff_y0 = y0;
        eff_w  = width;
        eff_h  = height;
    end
`endif

    assign zero_size = (eff_w == '0) || (eff_h == '0);

    // cx/cy index the pixel currently on the outputs; cx_nx/cy_nx is the one to emit next.
    assign row_end = (cx == bw - X_W'(1));
    assign last_px = row_end && (cy == bh - Y_W'(1));
    assign cx_nx   = row_end ? '0 : cx + X_W'(1);
    assign cy_nx   = row_end ? cy + Y_W'(1) : cy;

    // The accepting edge already registers pixel 0, taken straight from the inputs.
    always_comb begin
        px_sum  = '0;
        py_sum  = '0;
        pix_col = bcol;
        if (state == S_IDLE) begin
            px_sum  = {1'b0, eff_x0};
            py_sum  = {1'b0, eff_y0};
            pix_col = colour_in;
        end else begin
            px_sum  = {1'b0, bx} + {1'b0, cx_nx};
            py_sum  = {1'b0, by} + {1'b0, cy_nx};
        end
    end

    assign px_vis = (px_sum < SCR_W) && (py_sum < SCR_H);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = zero_size ? S_DONE : S_DRAW;
                end
            end
            S_DRAW: begin
                if (last_px) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bx     <= '0;
            by     <= '0;
            bw     <= '0;
            bh     <= '0;
            bcol   <= '0;
            cx     <= '0;
            cy     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bx   <= eff_x0;
                        by   <= eff_y0;
                        bw   <= eff_w;
                        bh   <= eff_h;
                        bcol <= colour_in;
                        cx   <= '0;
                        cy   <= '0;
                        if (zero_size) begin
                            done <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            plot <= px_vis;
                            if (px_vis) begin
                                x      <= px_sum[X_W-1:0];
                                y      <= py_sum[Y_W-1:0];
                                colour <= pix_col;
                            end
                        end
                    end
                end
                S_DRAW: begin
                    if (last_px) begin
                        busy <= 1'b0;
                        plot <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        cx   <= cx_nx;
                        cy   <= cy_nx;
                        plot <= px_vis;
                        // Clipped pixels still consume a cycle; x/y/colour hold.
                        if (px_vis) begin
                            x      <= px_sum[X_W-1:0];
                            y      <= py_sum[Y_W-1:0];
                            colour <= pix_col;
                        end
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_box_fill.sv
// tb/tb_vga_box_fill.sv - table-driven bench for vga_box_fill
module tb_vga_box_fill;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    logic           clock = 1'b0;
    logic           resetn;
    logic           start;
    logic [X_W-1:0] x0, width;
    logic [Y_W-1:0] y0, height;
    logic [C_W-1:0] colour_in;
    logic           busy, done, plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
`ifdef VGA_BOX_CLEAR_EN
    logic           clear;
`endif

    always #5 clock = ~clock;

    vga_box_fill dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .x0        (x0),
        .y0        (y0),
        .width     (width),
        .height    (height),
        .colour_in (colour_in),
`ifdef VGA_BOX_CLEAR_EN
        .clear     (clear),
`endif
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    typedef struct {
        int x0, y0, w, h, col;
        int e_busy, e_plots, e_done;
        int e_fx, e_fy, e_lx, e_ly;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;
    int   both_high = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic scramble_inputs();
        start     = 1'b0;
        x0        = X_W'($urandom);
        y0        = Y_W'($urandom);
        width     = X_W'($urandom);
        height    = Y_W'($urandom);
        colour_in = C_W'($urandom);
`ifdef VGA_BOX_CLEAR_EN
        clear     = 1'b0;
`endif
    endtask

    // Called just after a negedge; returns just after the negedge following the done pulse.
    task automatic run_box(input int vx0, input int vy0, input int vw, input int vh, input int vcol,
                           output int busy_c, output int plot_c, output int done_i,
                           output int fx, output int fy, output int lx, output int ly,
                           output int bad_col);
        busy_c = 0; plot_c = 0; done_i = -1;
        fx = -1; fy = -1; lx = -1; ly = -1; bad_col = 0;
        x0 = X_W'(vx0); y0 = Y_W'(vy0);
        width = X_W'(vw); height = Y_W'(vh);
        colour_in = C_W'(vcol);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        scramble_inputs();
        for (int idx = 0; idx < 25000; idx++) begin
            if (busy) busy_c++;
            if (busy && done) both_high++;
            if (plot) begin
                plot_c++;
                if (fx < 0) begin
                    fx = int'(x);
                    fy = int'(y);
                end
                lx = int'(x);
                ly = int'(y);
                if (int'(colour) != vcol) bad_col++;
            end
            if (done) begin
                done_i = idx;
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        chk("done_single_cycle", int'(done), 0);
    endtask

    int bc, pc, di, fx, fy, lx, ly, bcl;

    initial begin
        vecs[0] = '{10,  5,   2,  2, 5,   4,  4,  4,   10,   5,  11,   6};
        vecs[1] = '{ 3,  3,   0,  3, 1,   0,  0,  0,   -1,  -1,  -1,  -1};
        vecs[2] = '{158, 119, 4,  2, 6,   8,  2,  8,  158, 119, 159, 119};
        vecs[3] = '{ 0,  0,   1,  1, 7,   1,  1,  1,    0,   0,   0,   0};
        vecs[4] = '{150, 0,  20,  1, 3,  20, 10, 20,  150,   0, 159,   0};
        vecs[5] = '{ 5,  2,   3,  0, 2,   0,  0,  0,   -1,  -1,  -1,  -1};
        vecs[6] = '{255, 127, 2,  2, 4,   4,  0,  4,   -1,  -1,  -1,  -1};
        vecs[7] = '{100, 110, 3, 12, 1,  36, 30, 36,  100, 110, 102, 119};

        resetn = 1'b0;
        scramble_inputs();
        repeat (3) @(negedge clock);
        chk("reset_busy",   int'(busy),   0);
        chk("reset_done",   int'(done),   0);
        chk("reset_plot",   int'(plot),   0);
        chk("reset_x",      int'(x),      0);
        chk("reset_y",      int'(y),      0);
        chk("reset_colour", int'(colour), 0);
        resetn = 1'b1;
        @(negedge clock);

        // Back-to-back vectors at minimum start spacing.
        for (int i = 0; i < 8; i++) begin
            run_box(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].col,
                    bc, pc, di, fx, fy, lx, ly, bcl);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].e_busy);
            chk($sformatf("v%0d_plot_cycles", i), pc, vecs[i].e_plots);
            chk($sformatf("v%0d_done_index",  i), di, vecs[i].e_done);
            chk($sformatf("v%0d_first_x",     i), fx, vecs[i].e_fx);
            chk($sformatf("v%0d_first_y",     i), fy, vecs[i].e_fy);
            chk($sformatf("v%0d_last_x",      i), lx, vecs[i].e_lx);
            chk($sformatf("v%0d_last_y",      i), ly, vecs[i].e_ly);
            chk($sformatf("v%0d_colour",      i), bcl, 0);
        end

        // Exact raster order of the 2x2 box, then held outputs after completion.
        begin
            int ex_plot[5] = '{1, 1, 1, 1, 0};
            int ex_x[5]    = '{10, 11, 10, 11, 11};
            int ex_y[5]    = '{5, 5, 6, 6, 6};
            int ex_busy[5] = '{1, 1, 1, 1, 0};
            int ex_done[5] = '{0, 0, 0, 0, 1};
            x0 = 8'd10; y0 = 7'd5; width = 8'd2; height = 7'd2; colour_in = 3'd5;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            scramble_inputs();
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("seq_plot%0d", i),   int'(plot),   ex_plot[i]);
                chk($sformatf("seq_x%0d", i),      int'(x),      ex_x[i]);
                chk($sformatf("seq_y%0d", i),      int'(y),      ex_y[i]);
                chk($sformatf("seq_busy%0d", i),   int'(busy),   ex_busy[i]);
                chk($sformatf("seq_done%0d", i),   int'(done),   ex_done[i]);
                chk($sformatf("seq_colour%0d", i), int'(colour), 5);
                @(negedge clock);
            end
            chk("seq_done_cleared", int'(done), 0);
        end

        // Start re-asserted with other fields while a 3x3 box is drawing.
        begin
            int plots = 0, dones = 0, badc = 0, maxx = 0;
            x0 = 8'd20; y0 = 7'd20; width = 8'd3; height = 7'd3; colour_in = 3'd2;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            x0 = 8'd0; y0 = 7'd0; width = 8'd5; height = 7'd5; colour_in = 3'd7;
            for (int i = 0; i < 14; i++) begin
                if (i == 6) start = 1'b0;
                if (plot) begin
                    plots++;
                    if (colour != 3'd2) badc++;
                    if (int'(x) > maxx) maxx = int'(x);
                end
                if (done) dones++;
                if (busy && done) both_high++;
                @(negedge clock);
            end
            chk("restart_plots",  plots, 9);
            chk("restart_dones",  dones, 1);
            chk("restart_colour", badc,  0);
            chk("restart_max_x",  maxx,  22);
        end

        // Reset while pixel 3 of a 4x4 box is on the outputs.
        begin
            int dones = 0;
            x0 = 8'd30; y0 = 7'd40; width = 8'd4; height = 7'd4; colour_in = 3'd6;
            start = 1'b1;
            @(posedge clock);
            @(negedge clock);
            scramble_inputs();
            repeat (3) @(negedge clock);
            chk("pre_reset_x", int'(x), 33);
            resetn = 1'b0;
            #1;
            chk("midreset_plot", int'(plot), 0);
            chk("midreset_busy", int'(busy), 0);
            chk("midreset_x",    int'(x),    0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                if (done) dones++;
            end
            resetn = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (done || busy) dones++;
            end
            chk("midreset_no_done", dones, 0);
            run_box(7, 8, 1, 1, 3, bc, pc, di, fx, fy, lx, ly, bcl);
            chk("post_reset_plots", pc, 1);
            chk("post_reset_busy",  bc, 1);
            chk("post_reset_x",     fx, 7);
            chk("post_reset_y",     fy, 8);
        end

`ifdef VGA_BOX_CLEAR_EN
        clear = 1'b1;
        run_box(50, 60, 3, 3, 0, bc, pc, di, fx, fy, lx, ly, bcl);
        chk("clear_plots",   pc, 19200);
        chk("clear_busy",    bc, 19200);
        chk("clear_done",    di, 19200);
        chk("clear_first_x", fx, 0);
        chk("clear_first_y", fy, 0);
        chk("clear_last_x",  lx, 159);
        chk("clear_last_y",  ly, 119);
        chk("clear_colour",  bcl, 0);
`endif

        chk("busy_done_overlap", both_high, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_box_fill.md
# vga_box_fill

Sequencing controller that draws filled, axis-aligned rectangles into `vga_adapter` (160x120, 3-bit colour). It accepts one rectangle command through a start/busy/done handshake. It then walks the rectangle in raster order and emits one `x`/`y`/`colour`/`plot` pixel write per clock. It sits between command logic (switch/key front end or a future game FSM) and the `vga_adapter` write port.

## Interface
Parameters:
- `X_W`, 8, width of x coordinate/width fields
- `Y_W`, 7, width of y coordinate/height fields
- `COLOUR_W`, 3, colour width
- `SCREEN_W`, 160, visible columns; pixels at x >= SCREEN_W are clipped
- `SCREEN_H`, 120, visible rows; pixels at y >= SCREEN_H are clipped

Ports:
- `clock`  in  1  system clock, 50 MHz (same clock as `vga_adapter`); one clock, all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  command strobe, sampled only in IDLE
- `x0`  in  X_W  rectangle left column
- `y0`  in  Y_W  rectangle top row
- `width`  in  X_W  columns, 0..255
- `height`  in  Y_W  rows, 0..127
- `colour_in`  in  COLOUR_W  fill colour
- `clear`  in  1  full-screen clear request, present only with `VGA_BOX_CLEAR_EN`
- `busy`  out  1  command accepted, pixels in progress
- `done`  out  1  one-cycle completion pulse
- `x`  out  X_W  pixel column to `vga_adapter`
- `y`  out  Y_W  pixel row to `vga_adapter`
- `colour`  out  COLOUR_W  pixel colour to `vga_adapter`
- `plot`  out  1  pixel write enable to `vga_adapter`

## Operation
- States: IDLE, DRAW, DONE.
- IDLE:
  - `start`=1 latches `x0`, `y0`, `width`, `height` and `colour_in`, and clears the column/row counters cx and cy.
  - If `width`==0 or `height`==0, next state is DONE and no pixel is emitted.
  - Otherwise next state is DRAW.
- DRAW:
  - Each cycle presents pixel (x0+cx, y0+cy).
  - cx increments each cycle. When cx == width-1, cx wraps to 0 and cy increments.
  - When cx == width-1 and cy == height-1, next state is DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Clipping: the sum is computed at X_W+1 / Y_W+1 bits. If x0+cx >= SCREEN_W or y0+cy >= SCREEN_H, `plot`=0 for that cycle, but the cycle is still consumed. Draw time is therefore always width*height cycles.
- `start` in DRAW or DONE is ignored; no queueing.
- Input fields are only sampled on the accepting edge and may change freely afterwards.
- `x`, `y` and `colour` hold their last values when `plot`=0.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `plot`=0, `x`=0, `y`=0, `colour`=0, state IDLE.
- Reset mid-operation: outputs go to reset values asynchronously, with no completion pulse.
- Start accepted at edge k:
  - `busy`=1 from edge k.
  - First pixel is valid in the cycle after edge k (`plot` high at k+1 if visible).
  - Pixel n (0-based) is at cycle k+1+n.
- Completion:
  - Last pixel is at cycle k+width*height.
  - `done` is high and `busy` low in cycle k+width*height+1.
  - Zero-size command: `done` is high in cycle k+1.
- Minimum start-to-start spacing is width*height+2 cycles; the next start is accepted the edge after the DONE cycle.
- `busy` and `done` are never high together.

## Configuration
- `VGA_BOX_CLEAR_EN` defined:
  - Adds the `clear` port.
  - `start`=1 with `clear`=1 ignores `x0`, `y0`, `width` and `height`, and uses 0, 0, SCREEN_W, SCREEN_H with `colour_in`.
  - Clear takes SCREEN_W*SCREEN_H = 19200 cycles.
- Not defined: no `clear` port; every command uses the input fields.

## Test plan
- Box at x0=10, y0=5, width=2, height=2, colour_in=5:
  - Four plot cycles: (10,5), (11,5), (10,6), (11,6), all colour 5.
  - `done` one cycle after (11,6); `busy` high exactly 4 cycles.
- width=0, height=3: `plot` never high; `done` in the cycle after acceptance.
- Clipping, x0=158, y0=119, width=4, height=2:
  - 8 draw cycles.
  - `plot` high only for (158,119) and (159,119).
- Start re-asserted with new fields while drawing a 3x3 box: ignored; exactly 9 pixels of the original box; single `done`.
- `resetn` low at pixel 3 of a 4x4 box:
  - `plot` and `busy` drop immediately; no `done`.
  - After release, a new 1x1 start draws one pixel.
- With `VGA_BOX_CLEAR_EN`, clear with colour 0:
  - 19200 plot cycles, first (0,0), last (159,119).
  - `done` follows.
